// File: rtl/seq_key_pkg.sv
// Shared types and helpers for the address-sequence key detector:
// FSM state encoding, Galois LFSR tap masks and key nibble extraction.
package seq_key_pkg;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_MATCH = 2'd1,
        S_OPEN  = 2'd2
    } state_t;

    // Widest packed key the extraction helper accepts (16 nibbles x 16 bits).
    localparam int KEY_BUS_W = 256;

    // Toggle masks for a right-shifting Galois LFSR, maximal length for 4..16 bits.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0E08;
            13:      taps = 16'h1C80;
            14:      taps = 16'h3802;
            15:      taps = 16'h6000;
            16:      taps = 16'hB400;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    function automatic logic [15:0] key_nib(input logic [KEY_BUS_W-1:0] key,
                                            input int i, input int nib_w);
        logic [KEY_BUS_W-1:0] shifted;
        shifted = key >> (i * nib_w);
        return shifted[15:0] & 16'((32'd1 << nib_w) - 32'd1);
    endfunction

endpackage

// File: rtl/seq_key_lfsr.sv
// Width-parametrised Galois LFSR with synchronous load of a fixed seed and
// single-step advance.
module seq_key_lfsr
    import seq_key_pkg::*;
#(
    parameter int             W        = 6,
    parameter logic [W-1:0]   SEED_VAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= SEED_VAL;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/seq_key_unlock.sv
// Address-sequence key detector: unlocks after a programmed nibble sequence and
// serves LFSR response words. Define SEQ_KEY_TIMEOUT_EN to relock after TIMEOUT_READS reads.
module seq_key_unlock
    import seq_key_pkg::*;
#(
    parameter int                        KEY_LEN       = 6,
    parameter int                        NIB_W         = 4,
    parameter logic [KEY_LEN*NIB_W-1:0]  KEY           = '0,
    parameter logic [NIB_W-1:0]          LOCK_NIB      = 4'hF,
    parameter int                        RESP_W        = 2,
    parameter int                        LFSR_W        = 6,
    parameter logic [LFSR_W-1:0]         SEED          = 6'h2D,
    parameter int                        TIMEOUT_READS = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sel_n,
    input  logic                         win,
    input  logic                         rd,
    input  logic                         strobe,
    input  logic [NIB_W-1:0]             nib,
    output logic [RESP_W-1:0]            resp,
    output logic                         resp_oe,
    output logic                         unlocked,
    output logic [$clog2(KEY_LEN+1)-1:0] seq_idx
);

    localparam int IW        = $clog2(KEY_LEN + 1);
    localparam int KEY_SLOTS = 1 << IW;

    if (KEY_LEN < 2)           begin : g_bad_len   $error("KEY_LEN must be at least 2");      end
    if (SEED == '0)            begin : g_bad_seed  $error("SEED must be nonzero");            end
    if (RESP_W > LFSR_W)       begin : g_bad_resp  $error("RESP_W must not exceed LFSR_W");   end
    if (LFSR_W < 4 || LFSR_W > 16) begin : g_bad_lfsr $error("LFSR_W must be 4..16");        end
    if (LOCK_NIB == KEY[NIB_W-1:0]) begin : g_bad_lock $error("LOCK_NIB collides with KEY[0]"); end
    if (TIMEOUT_READS < 1)     begin : g_bad_to    $error("TIMEOUT_READS must be positive");  end

    // Padded to a power of two so any idx value indexes a defined slot.
    logic [NIB_W-1:0] key_arr [KEY_SLOTS];
    for (genvar gi = 0; gi < KEY_SLOTS; gi++) begin : g_key
        if (gi < KEY_LEN) begin : g_used
            assign key_arr[gi] = NIB_W'(key_nib(KEY_BUS_W'(KEY), gi, NIB_W));
        end else begin : g_pad
            assign key_arr[gi] = '0;
        end
    end

    state_t            state_reg;
    logic [IW-1:0]     idx_reg;
    logic [LFSR_W-1:0] lfsr_val;
    logic              lfsr_unused;
    logic              qrd, qwr;
    logic              key_hit, last_hit, restart_hit;
    logic              lfsr_load, lfsr_step, timeout_hit, relock;

    assign qrd = strobe & ~sel_n & win & rd;
    assign qwr = strobe & ~sel_n & win & ~rd;

    assign key_hit     = (nib == key_arr[idx_reg]);
    assign last_hit    = key_hit && (idx_reg == IW'(KEY_LEN - 1));
    assign restart_hit = (nib == key_arr[0]);

    assign lfsr_load = qrd && (state_reg != S_OPEN) && last_hit;
    assign lfsr_step = qrd && (state_reg == S_OPEN);

`ifdef SEQ_KEY_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_READS + 1);
    logic [CW-1:0] to_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || lfsr_load) begin
            to_cnt_reg <= '0;
        end else if (lfsr_step) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt_reg == CW'(TIMEOUT_READS - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Lock nibble and timeout on the same read collapse into one relock.
    assign relock = lfsr_step && ((nib == LOCK_NIB) || timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_HUNT;
            idx_reg   <= '0;
        end else if (qwr) begin
            state_reg <= S_HUNT;
            idx_reg   <= '0;
        end else if (qrd) begin
            case (state_reg)
                S_OPEN: begin
                    if (relock) begin
                        state_reg <= S_HUNT;
                    end
                end
                default: begin
                    if (last_hit) begin
                        state_reg <= S_OPEN;
                        idx_reg   <= '0;
                    end else if (key_hit) begin
                        state_reg <= S_MATCH;
                        idx_reg   <= idx_reg + 1'b1;
                    end else if (restart_hit) begin
                        state_reg <= S_MATCH;
                        idx_reg   <= IW'(1);
                    end else begin
                        state_reg <= S_HUNT;
                        idx_reg   <= '0;
                    end
                end
            endcase
        end
    end

    seq_key_lfsr #(
        .W        (LFSR_W),
        .SEED_VAL (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    assign lfsr_unused = ^lfsr_val;
    assign unlocked    = (state_reg == S_OPEN);
    assign seq_idx     = idx_reg;
    assign resp_oe     = lfsr_step;
    assign resp        = resp_oe ? lfsr_val[RESP_W-1:0] : '0;

endmodule

// File: tb/tb_seq_key_unlock.sv
// Scoreboard bench for seq_key_unlock: key 5,A,3,C, lock nibble F, seed 2D;
// expected LFSR low bits from seed: 01,10,11,01,...
module tb_seq_key_unlock;

`ifdef SEQ_KEY_TIMEOUT_EN
    localparam int TO_READS = 3;
`else
    localparam int TO_READS = 64;
`endif

    logic       clk = 1'b0;
    logic       rst, sel_n, win, rd, strobe;
    logic [3:0] nib;
    logic [1:0] resp;
    logic       resp_oe, unlocked;
    logic [2:0] seq_idx;

    typedef struct packed { logic oe; logic [1:0] resp; } out_t;
    typedef struct packed { logic [2:0] idx; logic unl; } st_t;

    out_t out_q[$];
    st_t  st_q[$];
    out_t eo;
    st_t  es;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_pending = 0;

    always #5 clk = ~clk;

    seq_key_unlock #(
        .KEY_LEN       (4),
        .NIB_W         (4),
        .KEY           (16'hC3A5),
        .LOCK_NIB      (4'hF),
        .RESP_W        (2),
        .LFSR_W        (6),
        .SEED          (6'h2D),
        .TIMEOUT_READS (TO_READS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_n    (sel_n),
        .win      (win),
        .rd       (rd),
        .strobe   (strobe),
        .nib      (nib),
        .resp     (resp),
        .resp_oe  (resp_oe),
        .unlocked (unlocked),
        .seq_idx  (seq_idx)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: output checked in the strobe cycle, state checked the cycle after.
    always @(negedge clk) begin
        if (chk_pending) begin
            if (st_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL st_queue: got empty expected entry");
            end else begin
                es = st_q.pop_front();
                chk("seq_idx", 8'(seq_idx), 8'(es.idx));
                chk("unlocked", 8'(unlocked), 8'(es.unl));
            end
            chk_pending = 0;
        end
        if (strobe) begin
            if (out_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL out_queue: got empty expected entry");
            end else begin
                eo = out_q.pop_front();
                $display("[TB] txn rst=%b sel_n=%b win=%b rd=%b nib=%h -> oe=%b resp=%b (exp %b %b)",
                         rst, sel_n, win, rd, nib, resp_oe, resp, eo.oe, eo.resp);
                chk("resp_oe", 8'(resp_oe), 8'(eo.oe));
                chk("resp", 8'(resp), 8'(eo.resp));
            end
            chk_pending = 1;
        end
    end

    task automatic acc(input logic r, input logic sn, input logic w, input logic rdv,
                       input logic [3:0] n, input logic eoe, input logic [1:0] er,
                       input logic [2:0] ei, input logic eu);
        out_t o;
        st_t  s;
        @(posedge clk);
        #1;
        o.oe = eoe;  o.resp = er;
        s.idx = ei;  s.unl = eu;
        out_q.push_back(o);
        st_q.push_back(s);
        rst = r; sel_n = sn; win = w; rd = rdv; nib = n; strobe = 1'b1;
    endtask

    task automatic qr(input logic [3:0] n, input logic eoe, input logic [1:0] er,
                      input logic [2:0] ei, input logic eu);
        acc(1'b0, 1'b0, 1'b1, 1'b1, n, eoe, er, ei, eu);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        strobe = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic unlock_seq();
        qr(4'h5, 1'b0, 2'b00, 3'd1, 1'b0);
        qr(4'hA, 1'b0, 2'b00, 3'd2, 1'b0);
        qr(4'h3, 1'b0, 2'b00, 3'd3, 1'b0);
        qr(4'hC, 1'b0, 2'b00, 3'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; sel_n = 1'b1; win = 1'b0; rd = 1'b1; strobe = 1'b0; nib = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_idx", 8'(seq_idx), 8'd0);
        chk("reset_unlocked", 8'(unlocked), 8'd0);
        chk("reset_oe", 8'(resp_oe), 8'd0);
        chk("reset_resp", 8'(resp), 8'd0);

        // Unlock, then three served reads.
        unlock_seq();
        qr(4'h0, 1'b1, 2'b01, 3'd0, 1'b1);
        qr(4'h0, 1'b1, 2'b10, 3'd0, 1'b1);
`ifdef SEQ_KEY_TIMEOUT_EN
        qr(4'h0, 1'b1, 2'b11, 3'd0, 1'b0);
        qr(4'h0, 1'b0, 2'b00, 3'd0, 1'b0);
`else
        qr(4'h0, 1'b1, 2'b11, 3'd0, 1'b1);
        qr(4'hF, 1'b1, 2'b01, 3'd0, 1'b0);
        qr(4'h0, 1'b0, 2'b00, 3'd0, 1'b0);
`endif
        idle();

        // Restart on repeated first nibble, then lock read.
        qr(4'h5, 1'b0, 2'b00, 3'd1, 1'b0);
        qr(4'hA, 1'b0, 2'b00, 3'd2, 1'b0);
        qr(4'h5, 1'b0, 2'b00, 3'd1, 1'b0);
        qr(4'hA, 1'b0, 2'b00, 3'd2, 1'b0);
        qr(4'h3, 1'b0, 2'b00, 3'd3, 1'b0);
        qr(4'hC, 1'b0, 2'b00, 3'd0, 1'b1);
        qr(4'hF, 1'b1, 2'b01, 3'd0, 1'b0);
        qr(4'hF, 1'b0, 2'b00, 3'd0, 1'b0);
        idle();

        // Write aborts a partial sequence.
        qr(4'h5, 1'b0, 2'b00, 3'd1, 1'b0);
        qr(4'hA, 1'b0, 2'b00, 3'd2, 1'b0);
        acc(1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 2'b00, 3'd0, 1'b0);
        qr(4'h3, 1'b0, 2'b00, 3'd0, 1'b0);
        qr(4'hC, 1'b0, 2'b00, 3'd0, 1'b0);
        idle();

        // Out-of-window / deselected strobes are ignored; rst beats the final key strobe.
        qr(4'h5, 1'b0, 2'b00, 3'd1, 1'b0);
        acc(1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 2'b00, 3'd1, 1'b0);
        acc(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 2'b00, 3'd1, 1'b0);
        qr(4'hA, 1'b0, 2'b00, 3'd2, 1'b0);
        acc(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 2'b00, 3'd2, 1'b0);
        qr(4'h3, 1'b0, 2'b00, 3'd3, 1'b0);
        acc(1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 2'b00, 3'd0, 1'b0);
        idle();
        qr(4'h0, 1'b0, 2'b00, 3'd0, 1'b0);
        idle();

        // Lock nibble on the third read (coincides with timeout when enabled).
        unlock_seq();
        qr(4'h0, 1'b1, 2'b01, 3'd0, 1'b1);
        qr(4'h0, 1'b1, 2'b10, 3'd0, 1'b1);
        qr(4'hF, 1'b1, 2'b11, 3'd0, 1'b0);
        qr(4'h0, 1'b0, 2'b00, 3'd0, 1'b0);
        idle();

        // Write while open relocks.
        unlock_seq();
        acc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0, 1'b0);
        qr(4'h0, 1'b0, 2'b00, 3'd0, 1'b0);
        idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", 8'(out_q.size() + st_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_key_unlock.md
Name: seq_key_unlock

Overview:
- Parametrised address-sequence key detector for the bus-decoded security/serial-read path.
- Watches qualified read strobes inside a decoded window and compares a low-address nibble against a programmed key sequence.
- On a full match it unlocks and drives a pseudo-random response word on each subsequent qualified read.
- Successor to the fixed-key, fixed-width, single-bit-response registered decoder; adds configurable key, response width, explicit relock and optional timeout.

Parameters:
- KEY_LEN, 6, number of nibbles in the unlock sequence (2..16).
- NIB_W, 4, width of the compared address field.
- KEY, {NIB_W{1'b0}} x KEY_LEN packed, key nibbles; element 0 is matched first; bits [NIB_W-1:0] hold element 0.
- LOCK_NIB, 4'hF, nibble that relocks when read while unlocked.
- RESP_W, 2, width of the response output.
- LFSR_W, 6, response LFSR width (>= RESP_W, 4..16).
- SEED, 6'h2D, LFSR load value on unlock; must be nonzero.
- TIMEOUT_READS, 64, reads allowed while unlocked (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sel_n  in  1  active-low device select.
- win  in  1  address window decode (e.g. A13=0, A12=1), active high.
- rd  in  1  1 = read cycle, 0 = write.
- strobe  in  1  one-cycle pulse per bus access.
- nib  in  NIB_W  compared address field.
- resp  out  RESP_W  response data.
- resp_oe  out  1  response output enable.
- unlocked  out  1  high in S_OPEN.
- seq_idx  out  $clog2(KEY_LEN+1)  current match index, for debug.

Behaviour:
- Reset is synchronous and active-high (rst sampled on rising clk). On reset: state=S_HUNT, idx=0, lfsr=SEED, unlocked=0, resp=0, resp_oe=0.
- qrd = strobe & ~sel_n & win & rd.
- qwr = strobe & ~sel_n & win & ~rd.
- Strobes with sel_n=1 or win=0 are ignored: all state holds.
- States:
  - S_HUNT (idx=0).
  - S_MATCH (0<idx<KEY_LEN).
  - S_OPEN.
- S_HUNT/S_MATCH, on qrd:
  - nib==KEY[idx]: idx+1. If idx+1==KEY_LEN, go to S_OPEN, load lfsr=SEED, clear idx.
  - Mismatch: if nib==KEY[0], idx=1 (S_MATCH); else idx=0 (S_HUNT). The restart check takes priority over the abort.
- S_OPEN, on qrd:
  - lfsr advances one step (Galois, maximal-length taps from package).
  - If nib==LOCK_NIB, return to S_HUNT after this read completes. The response for this read is still driven.
- Any qwr in any state: go to S_HUNT, idx=0. This is the abort path.
- unlocked is a registered state decode. It rises the cycle after the final key strobe.
- resp_oe is combinational: resp_oe = qrd & (state==S_OPEN). Asserted in the same cycle as the strobe. Never asserted while locked; the locked bus reads float.
- resp = lfsr[RESP_W-1:0] pre-advance value, combinational from the register. It reads 0 whenever resp_oe=0.
- Consecutive strobes on back-to-back cycles are legal. Each strobe is processed independently.
- rst asserted mid-sequence or in S_OPEN has priority over every strobe in that cycle.
- Parameter checks (elaboration error):
  - KEY_LEN<2.
  - SEED==0.
  - RESP_W>LFSR_W.
  - LOCK_NIB==KEY[0].

Optional Feature:
- Macro SEQ_KEY_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_READS+1)-bit counter clears on entry to S_OPEN and counts qrd in S_OPEN.
  - The TIMEOUT_READS-th read is served normally, then the block returns to S_HUNT.
  - A LOCK_NIB read and the timeout in the same cycle behave identically (single relock).
- Undefined: no counter; S_OPEN is left only via LOCK_NIB, qwr or rst.

Decomposition:
- Package seq_key_pkg holds:
  - state enum {S_HUNT, S_MATCH, S_OPEN}.
  - Function lfsr_taps(width) returning the maximal tap mask for 4..16.
  - Function key_nib(KEY, i) extracting element i.
- One sub-module, seq_key_lfsr: width-parametrised Galois LFSR with load, step and value out.

Test Plan (KEY_LEN=4, KEY={C,3,A,5} i.e. 5,A,3,C in order, LOCK_NIB=F, RESP_W=2, LFSR_W=6, SEED=2D):
- Reset, then qrd nib 5,A,3,C on 4 strobes → unlocked=1 one cycle after the 4th; resp_oe=0 during all 4.
- Unlocked, 3 qrd nib=0 → resp_oe=1 each strobe; resp = lfsr[1:0] of SEED, step1, step2 (2'b01 first); unlocked stays 1.
- Sequence 5,A,5,A,3,C → second 5 restarts at idx=1; unlock after C; seq_idx trace 1,2,1,2,3,0.
- Sequence 5,A then qwr, then 3,C → abort to idx=0; remains locked; strobe with win=0 mid-sequence leaves idx unchanged.
- Unlocked, qrd nib=F → resp_oe=1 with valid resp, then unlocked=0 next cycle; following reads give resp_oe=0.
- With SEQ_KEY_TIMEOUT_EN, TIMEOUT_READS=3: unlock, 3 reads served, 4th read resp_oe=0; rst asserted together with the final key strobe → stays locked, idx=0.
